// File: rtl/fpu_issue_ctrl_if.sv
// Bundles the core request/response, fcsr access and FPU-facing signals of the
// FP issue stage. The slave view belongs to the issue controller, the master
// view to whatever drives it (core plus FPU model in a bench).
interface fpu_issue_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [2:0]  req_rm;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_rs2_lsb;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_flags;
    logic        resp_illegal;
    logic        resp_timeout;
    logic        csr_we;
    logic [7:0]  csr_wdata;
    logic [7:0]  csr_rdata;
    logic        fpu_start;
    logic [4:0]  fpu_op;
    logic [2:0]  fpu_rm;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic        fpu_rs2_lsb;
    logic [31:0] fpu_result;
    logic        fpu_done;
    logic        fpu_nv;
    logic        fpu_dz;
    logic        fpu_of;
    logic        fpu_uf;
    logic        fpu_nx;

    modport slave (
        input  req_valid, req_op, req_rm, req_a, req_b, req_rs2_lsb, flush,
               resp_ready, csr_we, csr_wdata, fpu_result, fpu_done,
               fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx,
        output req_ready, resp_valid, resp_data, resp_flags, resp_illegal,
               resp_timeout, csr_rdata, fpu_start, fpu_op, fpu_rm, fpu_a,
               fpu_b, fpu_rs2_lsb
    );

    modport master (
        output req_valid, req_op, req_rm, req_a, req_b, req_rs2_lsb, flush,
               resp_ready, csr_we, csr_wdata, fpu_result, fpu_done,
               fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx,
        input  req_ready, resp_valid, resp_data, resp_flags, resp_illegal,
               resp_timeout, csr_rdata, fpu_start, fpu_op, fpu_rm, fpu_a,
               fpu_b, fpu_rs2_lsb
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FP issue/response stage: accepts one op from the core, resolves the
// rounding mode against frm, launches the FPU with stable operands, and
// returns result plus flags. Owns frm/fflags with sticky accumulation, and
// handles flush (discard) and a watchdog that aborts a hung FPU.
module fpu_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input logic           clk,
    input logic           reset,
    fpu_issue_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, RESP} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [4:0]        op_q, op_d;
    logic [2:0]        rm_q, rm_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic              rs2_q, rs2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        frm_q, frm_d;
    logic [4:0]        fflags_q, fflags_d;
    logic [31:0]       data_q, data_d;
    logic [4:0]        flags_q, flags_d;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;

    logic [2:0]        rm_res;
    logic [4:0]        fpu_flags;
    logic [4:0]        fflags_base;

    // Next-state logic: dynamic rm uses the frm value held before any
    // same-cycle CSR write, and a CSR write is merged with captured flags.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rm_d      = rm_q;
        a_d       = a_q;
        b_d       = b_q;
        rs2_d     = rs2_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        flags_d   = flags_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;

        rm_res      = (bus.req_rm == 3'b111) ? frm_q : bus.req_rm;
        fpu_flags   = {bus.fpu_nv, bus.fpu_dz, bus.fpu_of, bus.fpu_uf, bus.fpu_nx};
        fflags_base = bus.csr_we ? bus.csr_wdata[4:0] : fflags_q;
        fflags_d    = fflags_base;
        frm_d       = bus.csr_we ? bus.csr_wdata[7:5] : frm_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && !bus.flush) begin
                    data_d    = 32'h0;
                    flags_d   = 5'b0;
                    illegal_d = 1'b0;
                    timeout_d = 1'b0;
                    if (rm_res >= 3'd5) begin
                        illegal_d = 1'b1;
                        state_d   = RESP;
                    end else begin
                        op_d    = bus.req_op;
                        rm_d    = rm_res;
                        a_d     = bus.req_a;
                        b_d     = bus.req_b;
                        rs2_d   = bus.req_rs2_lsb;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (bus.flush) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = DRAIN;
                end else if (bus.fpu_done) begin
                    data_d   = bus.fpu_result;
                    flags_d  = fpu_flags;
                    fflags_d = fflags_base | fpu_flags;
                    state_d  = RESP;
                end else if (cnt_q >= CNT_LAST) begin
                    data_d    = 32'h7FC0_0000;
                    flags_d   = 5'b10000;
                    timeout_d = 1'b1;
                    fflags_d  = fflags_base | 5'b10000;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (bus.fpu_done || cnt_q >= CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.flush || bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, all cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            rm_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rs2_q     <= 1'b0;
            cnt_q     <= '0;
            frm_q     <= '0;
            fflags_q  <= '0;
            data_q    <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rm_q      <= rm_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rs2_q     <= rs2_d;
            cnt_q     <= cnt_d;
            frm_q     <= frm_d;
            fflags_q  <= fflags_d;
            data_q    <= data_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // The counter is zero only in the first BUSY cycle, which makes it the start marker.
    assign bus.fpu_start    = (state_q == BUSY) && (cnt_q == '0);
    assign bus.req_ready    = (state_q == IDLE);
    assign bus.resp_valid   = (state_q == RESP);
    assign bus.resp_data    = data_q;
    assign bus.resp_flags   = flags_q;
    assign bus.resp_illegal = illegal_q;
    assign bus.resp_timeout = timeout_q;
    assign bus.csr_rdata    = {frm_q, fflags_q};
    assign bus.fpu_op       = op_q;
    assign bus.fpu_rm       = rm_q;
    assign bus.fpu_a        = a_q;
    assign bus.fpu_b        = b_q;
    assign bus.fpu_rs2_lsb  = rs2_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: a table of single-op vectors with
// hand-computed responses and fflags, followed by hand-written sequences for
// flush, CSR collisions and mid-operation reset.
module tb_fpu_issue_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fpu_issue_ctrl_if bus();

    fpu_issue_ctrl #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        csrWe;
        logic [7:0]  csrData;
        logic [4:0]  op;
        logic [2:0]  rm;
        logic [31:0] a;
        logic [31:0] b;
        logic        rs2;
        logic [31:0] result;
        logic [4:0]  fpuFlags;
        int          doneAfter;
        int          holdCycles;
        logic [31:0] expData;
        logic [4:0]  expFlags;
        logic        expIllegal;
        logic        expTimeout;
        int          expLatency;
        int          expStarts;
        logic [2:0]  expRm;
        logic [4:0]  expFflags;
    } vector_t;

    vector_t vectors[8];

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a sequence hangs.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vector_t v);
        int cycles;
        int starts;
        int holdErr;
        int unstable;
        logic [2:0]  seenRm;
        logic [4:0]  seenOp;
        logic [31:0] seenB;
        logic        seenRs2;
        cycles   = 0;
        starts   = 0;
        holdErr  = 0;
        unstable = 0;
        seenRm   = 3'b0;
        seenOp   = 5'b0;
        seenB    = 32'b0;
        seenRs2  = 1'b0;
        if (v.csrWe) begin
            bus.csr_we    = 1'b1;
            bus.csr_wdata = v.csrData;
            tick();
            bus.csr_we    = 1'b0;
        end
        bus.req_op      = v.op;
        bus.req_rm      = v.rm;
        bus.req_a       = v.a;
        bus.req_b       = v.b;
        bus.req_rs2_lsb = v.rs2;
        bus.req_valid   = 1'b1;
        checkOutput("req_ready_idle", bus.req_ready, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        while (cycles < 200 && bus.resp_valid !== 1'b1) begin
            if (bus.fpu_start === 1'b1) starts++;
            if (cycles == 0) begin
                seenRm  = bus.fpu_rm;
                seenOp  = bus.fpu_op;
                seenB   = bus.fpu_b;
                seenRs2 = bus.fpu_rs2_lsb;
            end
            if (bus.fpu_a !== v.a || bus.fpu_b !== v.b) holdErr++;
            if (v.doneAfter >= 0 && cycles == v.doneAfter) begin
                bus.fpu_done   = 1'b1;
                bus.fpu_result = v.result;
                {bus.fpu_nv, bus.fpu_dz, bus.fpu_of, bus.fpu_uf, bus.fpu_nx} = v.fpuFlags;
            end
            tick();
            bus.fpu_done = 1'b0;
            {bus.fpu_nv, bus.fpu_dz, bus.fpu_of, bus.fpu_uf, bus.fpu_nx} = 5'b0;
            cycles++;
        end
        checkOutput("resp_valid", bus.resp_valid, 1'b1);
        checkOutput("latency", cycles + 1, v.expLatency);
        checkOutput("start_pulses", starts, v.expStarts);
        checkOutput("resp_data", bus.resp_data, v.expData);
        checkOutput("resp_flags", bus.resp_flags, v.expFlags);
        checkOutput("resp_illegal", bus.resp_illegal, v.expIllegal);
        checkOutput("resp_timeout", bus.resp_timeout, v.expTimeout);
        if (!v.expIllegal) begin
            checkOutput("fpu_rm", seenRm, v.expRm);
            checkOutput("fpu_op", seenOp, v.op);
            checkOutput("fpu_b", seenB, v.b);
            checkOutput("fpu_rs2_lsb", seenRs2, v.rs2);
            checkOutput("operand_hold", holdErr, 0);
        end
        for (int h = 0; h < v.holdCycles; h++) begin
            tick();
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== v.expData ||
                bus.resp_flags !== v.expFlags) unstable++;
        end
        if (v.holdCycles > 0) checkOutput("resp_stable", unstable, 0);
        checkOutput("fflags", bus.csr_rdata[4:0], v.expFflags);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        checkOutput("idle_after_resp", bus.req_ready, 1'b1);
    endtask

    // Main test sequence.
    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_op      = 5'b0;
        bus.req_rm      = 3'b0;
        bus.req_a       = 32'b0;
        bus.req_b       = 32'b0;
        bus.req_rs2_lsb = 1'b0;
        bus.flush       = 1'b0;
        bus.resp_ready  = 1'b0;
        bus.csr_we      = 1'b0;
        bus.csr_wdata   = 8'b0;
        bus.fpu_result  = 32'b0;
        bus.fpu_done    = 1'b0;
        {bus.fpu_nv, bus.fpu_dz, bus.fpu_of, bus.fpu_uf, bus.fpu_nx} = 5'b0;

        //                csrWe csrData op     rm      a             b             rs2   result        flags     k   hold  expData       expFlags  ill   to    lat starts expRm   expFflags
        vectors[0] = '{1'b0, 8'h00, 5'h00, 3'b000, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5'b00000, 3,  0, 32'h40400000, 5'b00000, 1'b0, 1'b0, 5,  1, 3'b000, 5'b00000};
        vectors[1] = '{1'b1, 8'hA0, 5'h01, 3'b111, 32'h00000001, 32'h00000002, 1'b1, 32'h00000000, 5'b00000, 0,  0, 32'h00000000, 5'b00000, 1'b1, 1'b0, 1,  0, 3'b000, 5'b00000};
        vectors[2] = '{1'b1, 8'h20, 5'h03, 3'b111, 32'h40490FDB, 32'h3F000000, 1'b1, 32'h12345678, 5'b00001, 0,  0, 32'h12345678, 5'b00001, 1'b0, 1'b0, 2,  1, 3'b001, 5'b00001};
        vectors[3] = '{1'b0, 8'h00, 5'h04, 3'b010, 32'hC0000000, 32'h41200000, 1'b0, 32'hAABBCCDD, 5'b00101, 1,  4, 32'hAABBCCDD, 5'b00101, 1'b0, 1'b0, 3,  1, 3'b010, 5'b00101};
        vectors[4] = '{1'b0, 8'h00, 5'h05, 3'b101, 32'h11111111, 32'h22222222, 1'b0, 32'h00000000, 5'b00000, 0,  0, 32'h00000000, 5'b00000, 1'b1, 1'b0, 1,  0, 3'b000, 5'b00101};
        vectors[5] = '{1'b0, 8'h00, 5'h06, 3'b000, 32'h7F800000, 32'hFF800000, 1'b0, 32'h00000000, 5'b00000, -1, 0, 32'h7FC00000, 5'b10000, 1'b0, 1'b1, 65, 1, 3'b000, 5'b10101};
        vectors[6] = '{1'b1, 8'h80, 5'h07, 3'b111, 32'h3F000000, 32'h3E800000, 1'b1, 32'h55555555, 5'b10010, 2,  0, 32'h55555555, 5'b10010, 1'b0, 1'b0, 4,  1, 3'b100, 5'b10010};
        vectors[7] = '{1'b0, 8'h00, 5'h08, 3'b110, 32'h33333333, 32'h44444444, 1'b0, 32'h00000000, 5'b00000, 0,  0, 32'h00000000, 5'b00000, 1'b1, 1'b0, 1,  0, 3'b000, 5'b10010};

        tick();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("rst_req_ready", bus.req_ready, 1'b1);
        checkOutput("rst_resp_valid", bus.resp_valid, 1'b0);
        checkOutput("rst_fpu_start", bus.fpu_start, 1'b0);
        checkOutput("rst_csr_rdata", bus.csr_rdata, 8'h00);
        checkOutput("rst_resp_data", bus.resp_data, 32'h0);
        checkOutput("rst_fpu_a", bus.fpu_a, 32'h0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vectors[i]);
        end

        // Flush one cycle after start; FPU finishes two cycles later.
        bus.req_rm    = 3'b000;
        bus.req_a     = 32'h11111111;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        checkOutput("flush_start", bus.fpu_start, 1'b1);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checkOutput("drain_resp_valid", bus.resp_valid, 1'b0);
        checkOutput("drain_req_ready", bus.req_ready, 1'b0);
        tick();
        bus.fpu_done = 1'b1;
        {bus.fpu_nv, bus.fpu_dz, bus.fpu_of, bus.fpu_uf, bus.fpu_nx} = 5'b11111;
        tick();
        bus.fpu_done = 1'b0;
        {bus.fpu_nv, bus.fpu_dz, bus.fpu_of, bus.fpu_uf, bus.fpu_nx} = 5'b0;
        checkOutput("flush_req_ready", bus.req_ready, 1'b1);
        checkOutput("flush_resp_valid", bus.resp_valid, 1'b0);
        checkOutput("flush_fflags", bus.csr_rdata[4:0], 5'b10010);

        // Flush in the same cycle as done: the result is dropped.
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid  = 1'b0;
        bus.flush      = 1'b1;
        bus.fpu_done   = 1'b1;
        bus.fpu_nx     = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.fpu_done = 1'b0;
        bus.fpu_nx   = 1'b0;
        checkOutput("flushdone_resp_valid", bus.resp_valid, 1'b0);
        checkOutput("flushdone_req_ready", bus.req_ready, 1'b0);
        bus.fpu_done = 1'b1;
        tick();
        bus.fpu_done = 1'b0;
        checkOutput("flushdone_idle", bus.req_ready, 1'b1);
        checkOutput("flushdone_fflags", bus.csr_rdata[4:0], 5'b10010);

        // Flush in IDLE blocks acceptance.
        bus.req_valid = 1'b1;
        bus.flush     = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        checkOutput("idleflush_req_ready", bus.req_ready, 1'b1);
        checkOutput("idleflush_start", bus.fpu_start, 1'b0);

        // CSR write coinciding with flag capture merges both.
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid  = 1'b0;
        bus.fpu_done   = 1'b1;
        bus.fpu_result = 32'h00000001;
        bus.fpu_nx     = 1'b1;
        bus.csr_we     = 1'b1;
        bus.csr_wdata  = 8'h68;
        tick();
        bus.fpu_done = 1'b0;
        bus.fpu_nx   = 1'b0;
        bus.csr_we   = 1'b0;
        checkOutput("csrmerge_resp_valid", bus.resp_valid, 1'b1);
        checkOutput("csrmerge_rdata", bus.csr_rdata, 8'h69);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;

        // frm write at acceptance does not change that op's rm; then reset in BUSY.
        bus.req_rm    = 3'b111;
        bus.req_valid = 1'b1;
        bus.csr_we    = 1'b1;
        bus.csr_wdata = 8'h00;
        tick();
        bus.req_valid = 1'b0;
        bus.csr_we    = 1'b0;
        bus.req_rm    = 3'b000;
        checkOutput("oldfrm_fpu_rm", bus.fpu_rm, 3'b011);
        checkOutput("oldfrm_start", bus.fpu_start, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rstbusy_req_ready", bus.req_ready, 1'b1);
        checkOutput("rstbusy_start", bus.fpu_start, 1'b0);
        checkOutput("rstbusy_fpu_a", bus.fpu_a, 32'h0);
        checkOutput("rstbusy_fpu_rm", bus.fpu_rm, 3'b000);
        checkOutput("rstbusy_csr", bus.csr_rdata, 8'h00);

        // Reset while a response is waiting.
        bus.csr_we    = 1'b1;
        bus.csr_wdata = 8'hFF;
        tick();
        bus.csr_we    = 1'b0;
        bus.req_a     = 32'h87654321;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid  = 1'b0;
        bus.fpu_done   = 1'b1;
        bus.fpu_result = 32'hDEADBEEF;
        bus.fpu_nx     = 1'b1;
        tick();
        bus.fpu_done = 1'b0;
        bus.fpu_nx   = 1'b0;
        checkOutput("rstresp_pre_valid", bus.resp_valid, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rstresp_valid", bus.resp_valid, 1'b0);
        checkOutput("rstresp_data", bus.resp_data, 32'h0);
        checkOutput("rstresp_flags", bus.resp_flags, 5'b0);
        checkOutput("rstresp_csr", bus.csr_rdata, 8'h00);
        checkOutput("rstresp_fpu_a", bus.fpu_a, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
